// File: rtl/shift_mode_ctrl_if.sv
// Command bus between the shift sequencer and the 4-bit universal shift register.
// The master drives requests and returns QA/QD; the slave (sequencer) drives mode and data.
interface shift_mode_ctrl_if;
    logic       start;
    logic       stop;
    logic       ring;
    logic       fill;
    logic [3:0] pattern;
    logic       QA;
    logic       QD;
    logic       S1;
    logic       S0;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic       SL;
    logic       SR;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, ring, fill, pattern, QA, QD,
        input  S1, S0, A, B, C, D, SL, SR, busy, done
    );

    modport slave (
        input  start, stop, ring, fill, pattern, QA, QD,
        output S1, S0, A, B, C, D, SL, SR, busy, done
    );
endinterface

// File: rtl/shift_mode_ctrl.sv
// Sequencer for a 4-bit universal shift register: loads a pattern, then issues timed
// rotate-right (ring) or right-then-left (bounce) shift commands. All outputs registered.
module shift_mode_ctrl #(
    parameter int              DIV_W   = 24,
    parameter logic [DIV_W-1:0] DIV_MAX = 2,
    parameter int              STEPS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_mode_ctrl_if.slave sm
);
    localparam logic [3:0] STEPS_C = 4'(STEPS);

    typedef enum logic [2:0] {IDLE, LOAD, RUN_R, RUN_L, FINISH} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       step_q, step_d;
    logic [3:0]       pat_q, pat_d;
    logic             ring_q, ring_d;
    logic             fill_q, fill_d;
    logic [1:0]       s_q, s_d;
    logic             sl_q, sl_d;
    logic             sr_q, sr_d;
    logic             busy_q, done_q;
    logic             run, tick;

    // The divider also runs during LOAD so the first shift lands DIV_MAX+1 cycles after it.
    assign run  = (state_q inside {LOAD, RUN_R, RUN_L});
    assign tick = run && (div_q == DIV_MAX);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        step_d  = step_q;
        pat_d   = pat_q;
        ring_d  = ring_q;
        fill_d  = fill_q;
        s_d     = 2'b00;
        if (run)
            div_d = tick ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (sm.start && !sm.stop) begin
                    state_d = LOAD;
                    pat_d   = sm.pattern;
                    ring_d  = sm.ring;
                    fill_d  = sm.fill;
                end
            end
            LOAD, RUN_R: begin
                state_d = RUN_R;
                if (tick) begin
                    s_d = 2'b01;
                    if (!ring_q) begin
                        if (step_q + 4'd1 == STEPS_C) begin
                            step_d  = '0;
                            state_d = RUN_L;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                end
            end
            RUN_L: begin
                // Wait out the last left-shift cycle so FINISH itself carries S=00.
                if (step_q == STEPS_C) begin
                    state_d = FINISH;
                end else if (tick) begin
                    s_d    = 2'b10;
                    step_d = step_q + 4'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (sm.stop && state_q != IDLE) begin
            state_d = IDLE;
            s_d     = 2'b00;
        end
        if (state_d == LOAD) begin
            s_d    = 2'b11;
            div_d  = '0;
            step_d = '0;
        end
        if (state_d == IDLE || state_d == FINISH) begin
            div_d  = '0;
            step_d = '0;
        end

        sr_d = ring_q ? sm.QD : fill_q;
        sl_d = ring_q ? 1'b0  : fill_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            step_q  <= '0;
            pat_q   <= '0;
            ring_q  <= 1'b0;
            fill_q  <= 1'b0;
            s_q     <= 2'b00;
            sl_q    <= 1'b0;
            sr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            pat_q   <= pat_d;
            ring_q  <= ring_d;
            fill_q  <= fill_d;
            s_q     <= s_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FINISH);
        end
    end

    assign sm.S1   = s_q[1];
    assign sm.S0   = s_q[0];
    assign sm.A    = pat_q[3];
    assign sm.B    = pat_q[2];
    assign sm.C    = pat_q[1];
    assign sm.D    = pat_q[0];
    assign sm.SL   = sl_q;
    assign sm.SR   = sr_q;
    assign sm.busy = busy_q;
    assign sm.done = done_q;
endmodule
